// File: rtl/swi_ret_if.sv
// Pipeline-facing bundle of the SWI return unit: EX-stage requests in, return branch and stack status out.
interface swi_ret_if #(
    parameter int DEPTH = 8,
    parameter int AW    = 48
);
    localparam int DW = $clog2(DEPTH) + 1;

    logic          iw_swi_valid;
    logic [AW-1:0] iw_swi_lr;
    logic          iw_sret_valid;
    logic          iw_stall;
    logic          iw_flush;
    logic          iw_fault_clr;
    logic          ow_ret_taken;
    logic [AW-1:0] ow_ret_pc;
    logic [DW-1:0] ow_depth;
    logic          ow_empty;
    logic          ow_full;
    logic          ow_fault;
    logic [1:0]    ow_fault_code;

    modport master (
        output iw_swi_valid, iw_swi_lr, iw_sret_valid, iw_stall, iw_flush, iw_fault_clr,
        input  ow_ret_taken, ow_ret_pc, ow_depth, ow_empty, ow_full, ow_fault, ow_fault_code
    );

    modport slave (
        input  iw_swi_valid, iw_swi_lr, iw_sret_valid, iw_stall, iw_flush, iw_fault_clr,
        output ow_ret_taken, ow_ret_pc, ow_depth, ow_empty, ow_full, ow_fault, ow_fault_code
    );
endinterface

// File: rtl/swi_ret_unit.sv
// Hardware return-address stack for SWI/SRET: pushes LR on SWI, pops on SRET and
// issues a one-cycle return branch to fetch.
module swi_ret_unit #(
    parameter int DEPTH = 8,
    parameter int AW    = 48
) (
    input  logic      iw_clk,
    input  logic      iw_rst,
    swi_ret_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int DW = PW + 1;
    localparam logic [1:0] FC_NONE = 2'b00;
    localparam logic [1:0] FC_OVF  = 2'b01;
    localparam logic [1:0] FC_UNF  = 2'b10;

    typedef enum logic {IDLE, RET} state_t;

    state_t        state;
    logic [PW-1:0] sp;
    logic [PW-1:0] sp_m1;
    logic [DW-1:0] depth;
    logic [AW-1:0] ret_pc;
    logic          fault;
    logic [1:0]    fault_code;
    logic [AW-1:0] mem [DEPTH];

    logic accept, empty, full;
    logic do_pop, do_push, ovf, unf;
    logic [PW-1:0] wr_addr;

    assign accept  = ~bus.iw_stall & ~bus.iw_flush;
    assign empty   = (depth == '0);
    assign full    = (depth == DW'(DEPTH));
    assign sp_m1   = sp - 1'b1;

    // A pop in the same cycle frees a slot, so SWI+SRET on a full stack is legal.
    assign do_pop  = accept & bus.iw_sret_valid & ~empty;
    assign do_push = accept & bus.iw_swi_valid & (~full | do_pop);
    assign ovf     = accept & bus.iw_swi_valid & full & ~do_pop;
    assign unf     = accept & bus.iw_sret_valid & empty;
    assign wr_addr = do_pop ? sp_m1 : sp;

    always_ff @(posedge iw_clk or negedge iw_rst) begin
        if (!iw_rst) begin
            state      <= IDLE;
            sp         <= '0;
            depth      <= '0;
            ret_pc     <= '0;
            fault      <= 1'b0;
            fault_code <= FC_NONE;
        end else if (bus.iw_flush) begin
            state <= IDLE;
        end else if (!bus.iw_stall) begin
            state <= do_pop ? RET : IDLE;
            if (do_pop)
                ret_pc <= mem[sp_m1];

            // Pop+push replaces the top in place: SP and depth stay put.
            if (do_push && !do_pop) begin
                sp    <= sp + 1'b1;
                depth <= depth + 1'b1;
            end else if (do_pop && !do_push) begin
                sp    <= sp_m1;
                depth <= depth - 1'b1;
            end

            if (ovf || unf) begin
                fault <= 1'b1;
                if (!fault || bus.iw_fault_clr)
                    fault_code <= ovf ? FC_OVF : FC_UNF;
            end else if (bus.iw_fault_clr) begin
                fault      <= 1'b0;
                fault_code <= FC_NONE;
            end
        end
    end

    always_ff @(posedge iw_clk) begin
        if (do_push)
            mem[wr_addr] <= bus.iw_swi_lr;
    end

    assign bus.ow_ret_taken  = (state == RET);
    assign bus.ow_ret_pc     = ret_pc;
    assign bus.ow_depth      = depth;
    assign bus.ow_empty      = empty;
    assign bus.ow_full       = full;
    assign bus.ow_fault      = fault;
    assign bus.ow_fault_code = fault_code;
endmodule

// File: tb/tb_swi_ret_unit.sv
// Directed bench for swi_ret_unit (DEPTH=4): expected return targets go into a queue,
// a negedge monitor pops one per delivered (unstalled, unflushed) strobe.
module tb_swi_ret_unit;
    localparam int DEPTH = 4;
    localparam int AW    = 48;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [AW-1:0] exp_q [$];

    swi_ret_if #(.DEPTH(DEPTH), .AW(AW)) bus ();

    swi_ret_unit #(.DEPTH(DEPTH), .AW(AW)) dut (
        .iw_clk (clk),
        .iw_rst (rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: a strobe counts as delivered only in a cycle the pipeline accepts.
    always @(negedge clk) begin
        if (rst && bus.ow_ret_taken && !bus.iw_stall && !bus.iw_flush) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_strobe: got ret_pc %0h expected no strobe", bus.ow_ret_pc);
            end else begin
                logic [AW-1:0] e;
                e = exp_q.pop_front();
                if (bus.ow_ret_pc !== e) begin
                    n_errors++;
                    $display("FAIL ret_pc: got %0h expected %0h", bus.ow_ret_pc, e);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input logic swi, input logic [AW-1:0] lr, input logic sret,
                       input logic stall, input logic flush, input logic clr);
        bus.iw_swi_valid  = swi;
        bus.iw_swi_lr     = lr;
        bus.iw_sret_valid = sret;
        bus.iw_stall      = stall;
        bus.iw_flush      = flush;
        bus.iw_fault_clr  = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [AW-1:0] lr); cyc(1'b1, lr, 1'b0, 1'b0, 1'b0, 1'b0); endtask
    task automatic sret();  cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0); endtask
    task automatic idle();  cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0); endtask
    task automatic fclr();  cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1); endtask

    initial begin
        rst = 1'b1;
        bus.iw_swi_valid = 0; bus.iw_swi_lr = '0; bus.iw_sret_valid = 0;
        bus.iw_stall = 0; bus.iw_flush = 0; bus.iw_fault_clr = 0;
        #2 rst = 1'b0;
        #1;
        chk("rst_depth", bus.ow_depth, 0);
        chk("rst_empty", bus.ow_empty, 1);
        chk("rst_full", bus.ow_full, 0);
        chk("rst_ret_taken", bus.ow_ret_taken, 0);
        chk("rst_ret_pc", bus.ow_ret_pc, 0);
        chk("rst_fault", bus.ow_fault, 0);
        chk("rst_fault_code", bus.ow_fault_code, 0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;

        // LIFO order
        push(48'h000000000101);
        push(48'h0123456789AC);
        push(48'h000000000301);
        chk("lifo_depth", bus.ow_depth, 3);
        exp_q.push_back(48'h301);
        exp_q.push_back(48'h0123456789AC);
        exp_q.push_back(48'h101);
        sret(); sret(); sret();
        idle();
        chk("lifo_empty", bus.ow_empty, 1);
        chk("lifo_strobe_drop", bus.ow_ret_taken, 0);

        // Overflow at DEPTH=4
        for (int i = 1; i <= 4; i++) push(48'hA0 + 48'(i));
        chk("ovf_full", bus.ow_full, 1);
        chk("ovf_depth4", bus.ow_depth, 4);
        push(48'hA5);
        chk("ovf_fault", bus.ow_fault, 1);
        chk("ovf_code", bus.ow_fault_code, 2'b01);
        chk("ovf_depth", bus.ow_depth, 4);
        fclr();
        chk("ovf_clr_fault", bus.ow_fault, 0);
        chk("ovf_clr_code", bus.ow_fault_code, 0);
        for (int i = 4; i >= 1; i--) exp_q.push_back(48'hA0 + 48'(i));
        for (int i = 0; i < 4; i++) sret();
        idle();
        chk("ovf_drained", bus.ow_empty, 1);

        // Underflow
        sret();
        chk("unf_no_strobe", bus.ow_ret_taken, 0);
        chk("unf_fault", bus.ow_fault, 1);
        chk("unf_code", bus.ow_fault_code, 2'b10);
        chk("unf_depth", bus.ow_depth, 0);

        // First fault code sticks; pushes continue while faulted
        for (int i = 0; i < 4; i++) push(48'hB0 + 48'(i));
        push(48'hB4);
        chk("sticky_code", bus.ow_fault_code, 2'b10);
        chk("sticky_full", bus.ow_full, 1);
        fclr();
        chk("sticky_clr", bus.ow_fault, 0);
        for (int i = 3; i >= 0; i--) exp_q.push_back(48'hB0 + 48'(i));
        for (int i = 0; i < 4; i++) sret();
        idle();
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("clr_vs_new_fault", bus.ow_fault, 1);
        chk("clr_vs_new_code", bus.ow_fault_code, 2'b10);
        fclr();

        // Simultaneous SWI + SRET
        push(48'h100);
        exp_q.push_back(48'h100);
        cyc(1'b1, 48'h200, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("simul_depth", bus.ow_depth, 1);
        exp_q.push_back(48'h200);
        sret();
        idle();
        chk("simul_empty", bus.ow_empty, 1);
        cyc(1'b1, 48'h300, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("simul_empty_no_strobe", bus.ow_ret_taken, 0);
        chk("simul_empty_code", bus.ow_fault_code, 2'b10);
        chk("simul_empty_depth", bus.ow_depth, 1);
        fclr();
        exp_q.push_back(48'h300);
        sret();
        idle();

        // Stall / flush
        push(48'h500);
        push(48'h600);
        cyc(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("stall_depth", bus.ow_depth, 2);
        chk("stall_no_strobe", bus.ow_ret_taken, 0);
        sret();
        chk("flush_pre_pc", bus.ow_ret_pc, 48'h600);
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("flush_strobe_cleared", bus.ow_ret_taken, 0);
        chk("flush_depth", bus.ow_depth, 1);
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("flush_sret_ignored", bus.ow_depth, 1);
        chk("flush_sret_no_strobe", bus.ow_ret_taken, 0);
        exp_q.push_back(48'h500);
        sret();
        cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("stall_hold_strobe", bus.ow_ret_taken, 1);
        cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle();
        chk("stall_strobe_drop", bus.ow_ret_taken, 0);
        chk("stall_final_depth", bus.ow_depth, 0);

        // Async reset mid-cycle kills a pending strobe
        push(48'h700);
        push(48'h800);
        sret();
        chk("prereset_strobe", bus.ow_ret_taken, 1);
        chk("prereset_pc", bus.ow_ret_pc, 48'h800);
        #1 rst = 1'b0;
        #1;
        chk("async_depth", bus.ow_depth, 0);
        chk("async_ret_taken", bus.ow_ret_taken, 0);
        chk("async_ret_pc", bus.ow_ret_pc, 0);
        chk("async_empty", bus.ow_empty, 1);
        bus.iw_sret_valid = 0;
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;

        chk("queue_drained", 64'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
